// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: controller <-> datapath bundle; master drives controls from IR/jr/zero, slave is the datapath side
interface multicycle_main_control_if #(parameter int STATE_W = 4);
  logic [5:0] opcode;
  logic [5:0] func;
  logic jr;
  logic zero;
  logic [2:0] ALUOP;
  logic pc_we;
  logic ir_we;
  logic reg_we;
  logic mem_we;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic ext_op;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] pc_src;
  logic instr_done;
  logic illegal;
  logic [STATE_W-1:0] state;
  modport master (
    input opcode, func, jr, zero,
    output ALUOP, pc_we, ir_we, reg_we, mem_we, alu_src_a, alu_src_b, ext_op,
           reg_dst, mem_to_reg, pc_src, instr_done, illegal, state
  );
  modport slave (
    output opcode, func, jr, zero,
    input ALUOP, pc_we, ir_we, reg_we, mem_we, alu_src_a, alu_src_b, ext_op,
          reg_dst, mem_to_reg, pc_src, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: Moore FSM sequencing fetch/decode/execute/memory/writeback; clk, active-low sync reset, bus carries IR fields, jr/zero qualifiers and all datapath controls
module multicycle_main_control #(parameter int STATE_W = 4) (
  input logic clk,
  input logic reset,
  multicycle_main_control_if.master bus
);
  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    RWB    = STATE_W'(7),
    ORIEX  = STATE_W'(8),
    ORIWB  = STATE_W'(9),
    BRANCH = STATE_W'(10)
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  state_t state_q, state_d;
  logic illegal_q, illegal_d;
  logic pc_we, ir_we, reg_we, mem_we;
  logic legal, unused_func;
  assign unused_func = ^bus.func;
  assign legal = bus.opcode inside {OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};
  always_comb begin
    state_d = FETCH;
    illegal_d = illegal_q;
    pc_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    bus.ALUOP = 3'b000;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.ext_op = 1'b1;
    bus.reg_dst = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.pc_src = 2'b00;
    bus.instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        bus.alu_src_b = 2'b01;
        state_d = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                  (bus.opcode == OP_R)   ? EXEC :
                  (bus.opcode == OP_ORI) ? ORIEX :
                  (bus.opcode == OP_BEQ) ? BRANCH : FETCH;
        pc_we = bus.opcode == OP_J;
        bus.pc_src = (bus.opcode == OP_J) ? 2'b10 : 2'b00;
        bus.instr_done = bus.opcode == OP_J || !legal;
        illegal_d = illegal_q | !legal;
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: state_d = MEMWB;
      MEMWB: begin
        reg_we = 1'b1;
        bus.mem_to_reg = 2'b01;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        mem_we = 1'b1;
        bus.instr_done = 1'b1;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOP = 3'b010;
        pc_we = bus.jr;
        bus.pc_src = bus.jr ? 2'b11 : 2'b00;
        bus.instr_done = bus.jr;
        state_d = bus.jr ? FETCH : RWB;
      end
      RWB: begin
        bus.ALUOP = 3'b010;
        reg_we = 1'b1;
        bus.reg_dst = 2'b01;
        bus.instr_done = 1'b1;
      end
      ORIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op = 1'b0;
        bus.ALUOP = 3'b001;
        state_d = ORIWB;
      end
      ORIWB: begin
        reg_we = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOP = 3'b011;
        bus.pc_src = 2'b01;
        pc_we = bus.zero;
        bus.instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
  // Enables are gated by reset so an aborted instruction cannot write anything
  assign bus.pc_we = pc_we & reset;
  assign bus.ir_we = ir_we & reset;
  assign bus.reg_we = reg_we & reset;
  assign bus.mem_we = mem_we & reset;
  assign bus.state = state_q;
  assign bus.illegal = illegal_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main controller for the MIPS-subset CPU.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives all datapath enables and mux selects.
- Acts as the producer of the 3-bit ALUOP code consumed by ALU_Control.
- Takes back ALU_Control's jr flag and the ALU zero flag to resolve jr and beq.

Parameters:
- STATE_W, 4, width of state register (11 states used).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26] from instruction register.
- func  in  6  IR[5:0]; informational only, decode uses jr from ALU_Control.
- jr  in  1  jr flag from ALU_Control; valid while ALUOP=010.
- zero  in  1  ALU zero flag.
- ALUOP  out  3  to ALU_Control. 000=ADD, 001=OR, 010=R-type (func decides), 011=SUB.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- reg_we  out  1  GRF write enable.
- mem_we  out  1  DM write enable.
- alu_src_a  out  1  ALU A select. 0=PC, 1=rs data.
- alu_src_b  out  2  ALU B select. 00=rt data, 01=const 4, 10=extended imm, 11=sign-ext imm<<2.
- ext_op  out  1  extender mode. 1=sign, 0=zero.
- reg_dst  out  2  write register select. 00=rt, 01=rd.
- mem_to_reg  out  2  write data select. 00=ALUOut, 01=MDR.
- pc_src  out  2  PC source select. 00=ALU result, 01=ALUOut, 10={PC[31:28],imm26,00}, 11=rs data.
- instr_done  out  1  high during the final state of each instruction.
- illegal  out  1  sticky flag: an unsupported opcode was decoded.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM. Outputs decode combinationally from the state register, plus the opcode/jr/zero qualifiers noted below.
- Defaults in every state unless listed: all enables 0, selects 00, ext_op=1, ALUOP=000, instr_done=0.
- Reset: when reset=0 at a rising edge, state<=FETCH(0) and illegal<=0.
  - While reset=0, pc_we/ir_we/reg_we/mem_we are forced 0.
  - Reset mid-instruction aborts it. No partial write may occur from the reset cycle onward.
- Opcodes: R=000000, ori=001101, lw=100011, sw=101011, beq=000100, j=000010.
- States and transitions (encoding = state value):
  - FETCH(0): ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01, ALUOP=000, pc_src=00. -> DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, ALUOP=000 (branch target into ALUOut). Next state by opcode:
    - lw/sw -> MEMADR.
    - R -> EXEC.
    - ori -> ORIEX.
    - beq -> BRANCH.
    - j: pc_we=1, pc_src=10, instr_done=1 -> FETCH.
    - other: illegal<=1, instr_done=1 -> FETCH.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, ext_op=1, ALUOP=000. lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): -> MEMWB.
  - MEMWB(4): reg_we=1, reg_dst=00, mem_to_reg=01, instr_done=1. -> FETCH.
  - MEMWR(5): mem_we=1, instr_done=1. -> FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, ALUOP=010.
    - jr=1: pc_we=1, pc_src=11, instr_done=1 -> FETCH.
    - jr=0: -> RWB.
  - RWB(7): ALUOP=010 held, reg_we=1, reg_dst=01, mem_to_reg=00, instr_done=1. -> FETCH.
  - ORIEX(8): alu_src_a=1, alu_src_b=10, ext_op=0, ALUOP=001. -> ORIWB.
  - ORIWB(9): reg_we=1, reg_dst=00, mem_to_reg=00, instr_done=1. -> FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, ALUOP=011, pc_src=01, pc_we=zero, instr_done=1. -> FETCH.
  - Unused encodings 11-15: -> FETCH, with no enables asserted.
- Cycle counts including FETCH: lw 5, sw 4, R add/sub 4, jr 3, ori 4, beq 3, j 2, illegal 2.
- opcode is read only in DECODE, MEMADR, and for lw/sw selection. IR is stable after FETCH because ir_we=1 only in FETCH.
- jr is sampled only in EXEC. zero is sampled only in BRANCH.
- illegal stays set until reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with opcode=100011 -> state=0, all write enables 0, illegal=0. Release -> FETCH asserts ir_we=pc_we=1, ALUOP=000.
- lw (opcode 100011) -> state sequence 0,1,2,3,4. reg_we=1 only in state 4, with mem_to_reg=01. instr_done high in cycle 5 only.
- R add then jr: opcode 000000, jr=0 -> states 0,1,6,7, ALUOP=010 in 6 and 7, reg_dst=01. Then jr=1 -> states 0,1,6, pc_we=1 with pc_src=11, and reg_we never 1.
- beq: opcode 000100 with zero=1 -> pc_we=1, pc_src=01 in state 10. Repeat with zero=0 -> pc_we=0. Both return to FETCH in 3 cycles, ALUOP=011.
- ori: opcode 001101 -> states 0,1,8,9. ext_op=0 and ALUOP=001 in state 8. reg_we=1, reg_dst=00 in state 9.
- Illegal opcode 111111 -> illegal=1 after DECODE, back to FETCH. A following sw completes with mem_we=1 in state 5 and illegal still 1. Assert reset=0 during state 2 of a sw -> mem_we never asserted, state=0 next cycle.
